// File: rtl/cpu_pkg.sv
// cpu_pkg: instruction-set constants shared by the instruction encoder and
// the CPU decoder.
//   - 5-bit opcode field values (word bits [15:11])
//   - 3-bit operand mode field values (word bits [10:8])
//   - IF condition codes (word low byte)
//   - request operation / operand source enums
package cpu_pkg;

    localparam logic [4:0] OPC_NOP    = 5'b00000;
    localparam logic [4:0] OPC_OUT_LO = 5'b00001;
    localparam logic [4:0] OPC_LOAD   = 5'b10000;
    localparam logic [4:0] OPC_ADD    = 5'b10001;
    localparam logic [4:0] OPC_STORE  = 5'b10010;
    localparam logic [4:0] OPC_SUB    = 5'b10011;
    localparam logic [4:0] OPC_AND    = 5'b10100;
    localparam logic [4:0] OPC_OR     = 5'b10101;
    localparam logic [4:0] OPC_XOR    = 5'b10110;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_IF     = 5'b11110;

    localparam logic [2:0] MODE_CONST_LO = 3'b000;
    localparam logic [2:0] MODE_CONST_HI = 3'b001;
    localparam logic [2:0] MODE_DATA_LO  = 3'b010;
    localparam logic [2:0] MODE_DATA_HI  = 3'b011;
    localparam logic [2:0] MODE_RAM      = 3'b100;

    localparam logic [7:0] IF_COND_0 = 8'h00;
    localparam logic [7:0] IF_COND_1 = 8'h01;
    localparam logic [7:0] IF_COND_2 = 8'h10;
    localparam logic [7:0] IF_COND_3 = 8'h11;

    typedef enum logic [3:0] {
        OP_NOP    = 4'd0,
        OP_OUT_LO = 4'd1,
        OP_LOAD   = 4'd2,
        OP_STORE  = 4'd3,
        OP_ADD    = 4'd4,
        OP_SUB    = 4'd5,
        OP_AND    = 4'd6,
        OP_OR     = 4'd7,
        OP_XOR    = 4'd8,
        OP_BRANCH = 4'd9,
        OP_IF     = 4'd10
    } req_op_e;

    typedef enum logic [1:0] {
        SRC_IMM     = 2'd0,
        SRC_DATA_LO = 2'd1,
        SRC_DATA_HI = 2'd2,
        SRC_RAM     = 2'd3
    } req_src_e;

    // Opcode field for the operand-carrying operations; anything else maps to NOP.
    function automatic logic [4:0] alu_opcode(input req_op_e op);
        case (op)
            OP_LOAD:  return OPC_LOAD;
            OP_STORE: return OPC_STORE;
            OP_ADD:   return OPC_ADD;
            OP_SUB:   return OPC_SUB;
            OP_AND:   return OPC_AND;
            OP_OR:    return OPC_OR;
            OP_XOR:   return OPC_XOR;
            default:  return OPC_NOP;
        endcase
    endfunction

    // Map the two IF condition bits onto the nibble-spread condition byte.
    function automatic logic [7:0] if_cond_byte(input logic [1:0] cond);
        case (cond)
            2'd0:    return IF_COND_0;
            2'd1:    return IF_COND_1;
            2'd2:    return IF_COND_2;
            default: return IF_COND_3;
        endcase
    endfunction

endpackage

// File: rtl/inst_word_builder.sv
// inst_word_builder: packs an instruction word from its fields.
// Ports:
//   opcode   in  5   opcode field, word[15:11]
//   mode     in  3   operand mode field, word[10:8]
//   byte_val in  8   low byte, word[7:0]
//   word     out 16  assembled instruction word
module inst_word_builder (
    input  logic [4:0]  opcode,
    input  logic [2:0]  mode,
    input  logic [7:0]  byte_val,
    output logic [15:0] word
);

    assign word = {opcode, mode, byte_val};

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: turns operation requests into one or two 16-bit instruction
// words, each tagged with its program address.
// Ports:
//   clk, rst                        clock, async active-high reset
//   req_valid/req_ready             request handshake
//   req_op[3:0], req_src[1:0]       operation and operand source
//   req_arg[15:0]                   operand
//   out_valid/out_ready             output word handshake
//   out_word[15:0]                  encoded instruction
//   out_last                        final word of the current request
//   out_addr[7:0]                   program address of out_word
//   err                             one-cycle pulse after a rejected request
//
// state | meaning
// IDLE  | no word pending, ready for a request
// EMIT1 | first (or only) word of a request on the output
// EMIT2 | second word of a two-word immediate on the output
import cpu_pkg::*;

module inst_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [1:0]  req_src,
    input  logic [15:0] req_arg,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_word,
    output logic        out_last,
    output logic [7:0]  out_addr,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_e;

    state_e      state, state_nxt;
    logic        accept, out_hs;
    logic        reject, two_word;
    logic        load_first, load_second;
    logic [4:0]  op1, op2;
    logic [2:0]  mode1, mode2;
    logic [7:0]  byte1, byte2;
    logic [15:0] word1, word2, pend_word;
    logic [7:0]  arg_hi, arg_lo;
    logic        br_in_range;

    assign arg_hi = req_arg[15:8];
    assign arg_lo = req_arg[7:0];
    // -1024..1023 means bits [15:10] are a pure sign extension of bit 10.
    assign br_in_range = (req_arg[15:10] == 6'h00) || (req_arg[15:10] == 6'h3F);

    assign out_valid = (state != IDLE);
    assign out_hs    = out_valid & out_ready;
    // Gated by rst so nothing is accepted while reset is held.
    assign req_ready = !rst & ((state == IDLE) | (out_hs & out_last));
    assign accept    = req_valid & req_ready;

    always_comb begin
        reject   = 1'b0;
        two_word = 1'b0;
        op1      = OPC_NOP;
        mode1    = MODE_CONST_LO;
        byte1    = 8'h00;
        op2      = OPC_NOP;
        mode2    = MODE_CONST_LO;
        byte2    = 8'h00;
        case (req_op_e'(req_op))
            OP_NOP: op1 = OPC_NOP;
            OP_OUT_LO: op1 = OPC_OUT_LO;
            OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                op1 = alu_opcode(req_op_e'(req_op));
                if (req_op_e'(req_op) == OP_STORE && req_src_e'(req_src) != SRC_RAM)
                    reject = 1'b1;
                case (req_src_e'(req_src))
                    SRC_IMM: begin
                        if (arg_hi == 8'h00) begin
                            mode1 = MODE_CONST_LO;
                            byte1 = arg_lo;
                        end else if (arg_lo == 8'h00) begin
                            mode1 = MODE_CONST_HI;
                            byte1 = arg_hi;
                        end else if (req_op_e'(req_op) == OP_AND) begin
                            // AND cannot be split: the second half would clear the high byte.
                            reject = 1'b1;
                        end else begin
                            two_word = 1'b1;
                            mode1    = MODE_CONST_HI;
                            byte1    = arg_hi;
                            // LOAD of the high byte leaves the low byte zero, so OR fills it.
                            op2      = (req_op_e'(req_op) == OP_LOAD) ? OPC_OR : op1;
                            mode2    = MODE_CONST_LO;
                            byte2    = arg_lo;
                        end
                    end
                    SRC_DATA_LO: mode1 = MODE_DATA_LO;
                    SRC_DATA_HI: mode1 = MODE_DATA_HI;
                    default: begin
                        mode1 = MODE_RAM;
                        byte1 = arg_lo;
                        if (arg_hi != 8'h00)
                            reject = 1'b1;
                    end
                endcase
            end
            OP_BRANCH: begin
                op1   = OPC_BRANCH;
                mode1 = req_arg[10:8];
                byte1 = arg_lo;
                if (req_src_e'(req_src) != SRC_IMM || !br_in_range)
                    reject = 1'b1;
            end
            OP_IF: begin
                op1   = OPC_IF;
                byte1 = if_cond_byte(req_arg[1:0]);
            end
            default: reject = 1'b1;
        endcase
    end

    inst_word_builder u_build_first (
        .opcode   (op1),
        .mode     (mode1),
        .byte_val (byte1),
        .word     (word1)
    );

    inst_word_builder u_build_second (
        .opcode   (op2),
        .mode     (mode2),
        .byte_val (byte2),
        .word     (word2)
    );

    always_comb begin
        state_nxt   = state;
        load_first  = 1'b0;
        load_second = 1'b0;
        case (state)
            IDLE: begin
                if (accept && !reject) begin
                    state_nxt  = EMIT1;
                    load_first = 1'b1;
                end
            end
            EMIT1: begin
                if (out_hs) begin
                    if (!out_last) begin
                        state_nxt   = EMIT2;
                        load_second = 1'b1;
                    end else if (accept && !reject) begin
                        state_nxt  = EMIT1;
                        load_first = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            EMIT2: begin
                if (out_hs) begin
                    if (accept && !reject) begin
                        state_nxt  = EMIT1;
                        load_first = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_word  <= 16'h0000;
            out_last  <= 1'b0;
            out_addr  <= 8'h00;
            pend_word <= 16'h0000;
            err       <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= accept & reject;
            if (out_hs)
                out_addr <= out_addr + 8'd1;
            if (load_first) begin
                out_word  <= word1;
                out_last  <= !two_word;
                pend_word <= word2;
            end else if (load_second) begin
                out_word <= pend_word;
                out_last <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = 4'd0;
    logic [1:0]  req_src = 2'd0;
    logic [15:0] req_arg = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_word;
    logic        out_last;
    logic [7:0]  out_addr;
    logic        err;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_addr = 8'h00;

    inst_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_src   (req_src),
        .req_arg   (req_arg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_last  (out_last),
        .out_addr  (out_addr),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [1:0] src, input logic [15:0] arg);
        req_op    = op;
        req_src   = src;
        req_arg   = arg;
        req_valid = 1'b1;
    endtask

    task automatic test_reset();
        step();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
        checks++; if (out_word !== 16'h0000) begin errors++; $display("FAIL rst_out_word: got %h exp 0000", out_word); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b exp 0", out_last); end
        checks++; if (out_addr !== 8'h00) begin errors++; $display("FAIL rst_out_addr: got %h exp 00", out_addr); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", err); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b exp 0", req_ready); end
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b exp 1", req_ready); end
        exp_addr = 8'h00;
    endtask

    task automatic test_two_word();
        logic [3:0]  v_op  [2] = '{4'd2, 4'd5};
        logic [15:0] v_arg [2] = '{16'h1234, 16'hFFFF};
        logic [15:0] v_w1  [2] = '{16'h8112, 16'h99FF};
        logic [15:0] v_w2  [2] = '{16'hA834, 16'h98FF};
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(v_op[i], 2'd0, v_arg[i]);
            step();
            req_valid = 1'b0;
            checks++; if (out_valid !== 1'b1 || out_word !== v_w1[i] || out_last !== 1'b0 || out_addr !== exp_addr)
                begin errors++; $display("FAIL two_word_first[%0d]: got v=%b w=%h l=%b a=%h exp v=1 w=%h l=0 a=%h", i, out_valid, out_word, out_last, out_addr, v_w1[i], exp_addr); end
            step();
            exp_addr++;
            checks++; if (out_valid !== 1'b1 || out_word !== v_w2[i] || out_last !== 1'b1 || out_addr !== exp_addr)
                begin errors++; $display("FAIL two_word_second[%0d]: got v=%b w=%h l=%b a=%h exp v=1 w=%h l=1 a=%h", i, out_valid, out_word, out_last, out_addr, v_w2[i], exp_addr); end
            step();
            exp_addr++;
            checks++; if (out_valid !== 1'b0 || out_addr !== exp_addr)
                begin errors++; $display("FAIL two_word_done[%0d]: got v=%b a=%h exp v=0 a=%h", i, out_valid, out_addr, exp_addr); end
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        drive(4'd4, 2'd0, 16'h0042);
        step();
        checks++; if (out_word !== 16'h8842 || out_last !== 1'b1 || out_addr !== exp_addr)
            begin errors++; $display("FAIL b2b_add: got w=%h l=%b a=%h exp w=8842 l=1 a=%h", out_word, out_last, out_addr, exp_addr); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b exp 1", req_ready); end
        drive(4'd5, 2'd0, 16'h4200);
        step();
        req_valid = 1'b0;
        exp_addr++;
        checks++; if (out_valid !== 1'b1 || out_word !== 16'h9942 || out_last !== 1'b1 || out_addr !== exp_addr)
            begin errors++; $display("FAIL b2b_sub: got v=%b w=%h l=%b a=%h exp v=1 w=9942 l=1 a=%h", out_valid, out_word, out_last, out_addr, exp_addr); end
        step();
        exp_addr++;
        checks++; if (out_valid !== 1'b0 || out_addr !== exp_addr)
            begin errors++; $display("FAIL b2b_done: got v=%b a=%h exp v=0 a=%h", out_valid, out_addr, exp_addr); end
    endtask

    task automatic test_single();
        logic [3:0]  v_op  [12] = '{4'd9, 4'd9, 4'd9, 4'd10, 4'd10, 4'd3, 4'd0, 4'd1, 4'd8, 4'd4, 4'd7, 4'd2};
        logic [1:0]  v_src [12] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd3, 2'd3, 2'd1, 2'd2, 2'd1, 2'd0, 2'd3};
        logic [15:0] v_arg [12] = '{16'hFFFF, 16'hFC00, 16'h03FF, 16'h0003, 16'hFFF6, 16'h0010,
                                    16'hFFFF, 16'h1234, 16'h5555, 16'hFFFF, 16'hAB00, 16'h00FF};
        logic [15:0] v_exp [12] = '{16'hC7FF, 16'hC400, 16'hC3FF, 16'hF011, 16'hF010, 16'h9410,
                                    16'h0000, 16'h0800, 16'hB300, 16'h8A00, 16'hA9AB, 16'h84FF};
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(v_op[i], v_src[i], v_arg[i]);
            step();
            req_valid = 1'b0;
            checks++; if (out_valid !== 1'b1 || out_word !== v_exp[i] || out_last !== 1'b1 || out_addr !== exp_addr)
                begin errors++; $display("FAIL single[%0d]: got v=%b w=%h l=%b a=%h exp v=1 w=%h l=1 a=%h", i, out_valid, out_word, out_last, out_addr, v_exp[i], exp_addr); end
            step();
            exp_addr++;
        end
    endtask

    task automatic test_reject();
        logic [3:0]  v_op  [6] = '{4'd6, 4'd3, 4'd9, 4'd12, 4'd2, 4'd9};
        logic [1:0]  v_src [6] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3};
        logic [15:0] v_arg [6] = '{16'h1234, 16'h0010, 16'h0400, 16'h0000, 16'h0110, 16'h0001};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(v_op[i], v_src[i], v_arg[i]);
            step();
            req_valid = 1'b0;
            checks++; if (err !== 1'b1 || out_valid !== 1'b0 || out_addr !== exp_addr)
                begin errors++; $display("FAIL reject[%0d]: got err=%b v=%b a=%h exp err=1 v=0 a=%h", i, err, out_valid, out_addr, exp_addr); end
            step();
            checks++; if (err !== 1'b0 || out_valid !== 1'b0 || req_ready !== 1'b1)
                begin errors++; $display("FAIL reject_after[%0d]: got err=%b v=%b rdy=%b exp err=0 v=0 rdy=1", i, err, out_valid, req_ready); end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(4'd2, 2'd0, 16'h1234);
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1 || out_word !== 16'h8112 || out_last !== 1'b0 || out_addr !== exp_addr || req_ready !== 1'b0)
                begin errors++; $display("FAIL stall[%0d]: got v=%b w=%h l=%b a=%h rdy=%b exp v=1 w=8112 l=0 a=%h rdy=0", i, out_valid, out_word, out_last, out_addr, req_ready, exp_addr); end
            step();
        end
        out_ready = 1'b1;
        step();
        exp_addr++;
        checks++; if (out_valid !== 1'b1 || out_word !== 16'hA834 || out_last !== 1'b1 || out_addr !== exp_addr)
            begin errors++; $display("FAIL stall_resume: got v=%b w=%h l=%b a=%h exp v=1 w=A834 l=1 a=%h", out_valid, out_word, out_last, out_addr, exp_addr); end
        step();
        exp_addr++;
        checks++; if (out_valid !== 1'b0 || out_addr !== exp_addr)
            begin errors++; $display("FAIL stall_done: got v=%b a=%h exp v=0 a=%h", out_valid, out_addr, exp_addr); end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        out_ready = 1'b0;
        drive(4'd2, 2'd0, 16'h1234);
        step();
        req_valid = 1'b0;
        checks++; if (out_word !== 16'h8112) begin errors++; $display("FAIL midrst_first: got %h exp 8112", out_word); end
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_addr !== 8'h00 || req_ready !== 1'b0)
            begin errors++; $display("FAIL midrst_during: got v=%b a=%h rdy=%b exp v=0 a=00 rdy=0", out_valid, out_addr, req_ready); end
        step();
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        exp_addr = 8'h00;
        for (int i = 0; i < 4; i++) begin
            step();
            if (out_valid !== 1'b0 || out_word === 16'hA834 || out_addr !== 8'h00) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL midrst_after: got %0d cycles with stale output exp 0", bad); end
    endtask

    task automatic test_addr_wrap();
        int not_ready = 0;
        out_ready = 1'b1;
        drive(4'd0, 2'd0, 16'h0000);
        step();
        checks++; if (out_valid !== 1'b1 || out_addr !== exp_addr)
            begin errors++; $display("FAIL wrap_start: got v=%b a=%h exp v=1 a=%h", out_valid, out_addr, exp_addr); end
        for (int i = 0; i < 255; i++) begin
            step();
            exp_addr++;
            if (req_ready !== 1'b1 || out_valid !== 1'b1) not_ready++;
        end
        checks++; if (out_addr !== 8'hFF) begin errors++; $display("FAIL wrap_ff: got %h exp ff", out_addr); end
        checks++; if (not_ready != 0) begin errors++; $display("FAIL wrap_stream: got %0d stalled cycles exp 0", not_ready); end
        step();
        exp_addr++;
        checks++; if (out_addr !== 8'h00 || out_addr !== exp_addr) begin errors++; $display("FAIL wrap_00: got %h exp 00", out_addr); end
        req_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0 || out_addr !== 8'h01)
            begin errors++; $display("FAIL wrap_done: got v=%b a=%h exp v=0 a=01", out_valid, out_addr); end
    endtask

    initial begin
        test_reset();
        test_two_word();
        test_back_to_back();
        test_single();
        test_reject();
        test_backpressure();
        test_reset_mid();
        test_addr_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
